// File: rtl/jt51_pkg.sv
// Shared definitions for the key-on sequencer.
//   NUM_SLOTS  : number of time-multiplexed operator slots
//   GRP_*      : slot group of each operator (slot = grp*8 + ch)
//   OPB_*      : bit position of each operator in the 0x08 write data[6:3]
//   grp_opb()  : maps a slot group to its operator-enable bit
package jt51_pkg;

  localparam int NUM_SLOTS = 32;

  localparam int GRP_M1 = 0;
  localparam int GRP_M2 = 1;
  localparam int GRP_C1 = 2;
  localparam int GRP_C2 = 3;

  localparam int OPB_M1 = 0;
  localparam int OPB_C1 = 1;
  localparam int OPB_M2 = 2;
  localparam int OPB_C2 = 3;

  typedef logic [4:0]           slot_t;
  typedef logic [NUM_SLOTS-1:0] slot_vec_t;

  // Group order (M1,M2,C1,C2) and operator-bit order (M1,C1,M2,C2) differ,
  // so M2 and C1 swap when going from a write to a slot index.
  function automatic logic [1:0] grp_opb(input logic [1:0] grp);
    logic [1:0] opb;
    case (int'(grp))
      GRP_M1:  opb = 2'(OPB_M1);
      GRP_M2:  opb = 2'(OPB_M2);
      GRP_C1:  opb = 2'(OPB_C1);
      default: opb = 2'(OPB_C2);
    endcase
    return opb;
  endfunction

endpackage

// File: rtl/jt51_keyseq_if.sv
// Interface between the register/timer side and the key-on sequencer.
//   zero      : slot-0 marker from the timing generator (high when slot is 31)
//   kon_wr    : one-cycle strobe, write of register 0x08
//   kon_ch    : channel field of that write
//   kon_op    : operator enables of that write (bit0 M1, bit1 C1, bit2 M2, bit3 C2)
//   csm_trig  : one-cycle timer A overflow strobe in CSM mode
//   keyon     : key-on pulse for kon_slot
//   keyoff    : key-off pulse for kon_slot
//   kon_slot  : slot index the pulses refer to
//   kon_state : applied key state of kon_slot after its evaluation
// master drives the request side, slave (the sequencer) drives the pulses.
interface jt51_keyseq_if;
  import jt51_pkg::*;

  logic       zero;
  logic       kon_wr;
  logic [2:0] kon_ch;
  logic [3:0] kon_op;
  logic       csm_trig;
  logic       keyon;
  logic       keyoff;
  slot_t      kon_slot;
  logic       kon_state;

  modport master (
    output zero, kon_wr, kon_ch, kon_op, csm_trig,
    input  keyon, keyoff, kon_slot, kon_state
  );

  modport slave (
    input  zero, kon_wr, kon_ch, kon_op, csm_trig,
    output keyon, keyoff, kon_slot, kon_state
  );

endinterface

// File: rtl/jt51_keyseq.sv
// Key-on sequencer feeding the envelope generator.
// Keeps the requested key state of all 32 slots (register 0x08) plus the
// CSM key-on bookkeeping, and as the slot counter passes each slot emits a
// registered one-cycle keyon or keyoff pulse when the applied state changes.
//   clk  : system clock, one slot per cycle
//   rst  : synchronous active-high reset
//   bus  : jt51_keyseq_if.slave (write strobe, CSM trigger, zero marker in;
//          keyon/keyoff/kon_slot/kon_state out, one cycle after the slot)
// Parameter CSM_EN = 0 ties the CSM trigger off so the pending/active
// vectors stay at zero and are trimmed away.
module jt51_keyseq
  import jt51_pkg::*;
#(
  parameter int CSM_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  jt51_keyseq_if.slave bus
);

  slot_t     cnt_q, cnt_d;
  slot_vec_t req_q, req_d;
  slot_vec_t app_q, app_d;
  slot_vec_t pend_q, pend_d;
  slot_vec_t act_q, act_d;

  logic  keyon_q, keyon_d;
  logic  keyoff_q, keyoff_d;
  slot_t slot_q, slot_d;
  logic  state_q, state_d;

  logic cur_req, cur_app, cur_pend, cur_act;
  logic eff;
  logic trig;

  assign trig = (CSM_EN != 0) && bus.csm_trig;

  always_comb begin
    cnt_d  = bus.zero ? '0 : cnt_q + 5'd1;
    req_d  = req_q;
    app_d  = app_q;
    pend_d = pend_q;
    act_d  = act_q;

    // Evaluation of the current slot uses the vectors before any write
    // landing in this same cycle.
    cur_req  = req_q[cnt_q];
    cur_app  = app_q[cnt_q];
    cur_pend = pend_q[cnt_q];
    cur_act  = act_q[cnt_q];

    eff = cur_req | cur_pend | cur_act;

    // A CSM key-on lives for exactly one pass: on the following pass the
    // slot falls back to the register request.
    if (cur_act && !cur_pend) begin
      eff             = cur_req;
      act_d[cnt_q]    = 1'b0;
    end

    // A pending CSM key-on is consumed here; it only marks the slot as
    // CSM-keyed if the slot was off, otherwise it is absorbed silently.
    if (cur_pend) begin
      pend_d[cnt_q] = 1'b0;
      if (!cur_app) begin
        act_d[cnt_q] = 1'b1;
      end
    end

    app_d[cnt_q] = eff;

    keyon_d  = eff & ~cur_app;
    keyoff_d = ~eff & cur_app;
    slot_d   = cnt_q;
    state_d  = eff;

    if (bus.kon_wr) begin
      for (int g = 0; g < 4; g++) begin
        req_d[{2'(g), bus.kon_ch}] = bus.kon_op[grp_opb(2'(g))];
      end
    end

    // The trigger wins over the pending clear of the slot evaluated now.
    if (trig) begin
      pend_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      req_q    <= '0;
      app_q    <= '0;
      pend_q   <= '0;
      act_q    <= '0;
      keyon_q  <= 1'b0;
      keyoff_q <= 1'b0;
      slot_q   <= '0;
      state_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      app_q    <= app_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
      keyon_q  <= keyon_d;
      keyoff_q <= keyoff_d;
      slot_q   <= slot_d;
      state_q  <= state_d;
    end
  end

  assign bus.keyon     = keyon_q;
  assign bus.keyoff    = keyoff_q;
  assign bus.kon_slot  = slot_q;
  assign bus.kon_state = state_q;

endmodule

// File: tb/tb_jt51_keyseq.sv
module tb_jt51_keyseq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  jt51_keyseq_if kif();

  jt51_keyseq #(.CSM_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-slot request, on/off state and CSM-pending flag.
  // The applied state of a slot after its pass is simply request OR a
  // pending CSM key-on; the pending flag is consumed by that pass.
  bit m_req [32];
  bit m_on  [32];
  bit m_pend[32];
  int m_cnt;
  bit force_zero;
  int op_of_grp[4] = '{0, 2, 1, 3};

  int on_cnt [32];
  int off_cnt[32];

  typedef struct {
    int          at;
    bit          wr;
    bit          trig;
    logic [2:0]  ch;
    logic [3:0]  op;
    int          run;
    logic [31:0] on_mask;
    logic [31:0] off_mask;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_req[i]  = 1'b0;
      m_on[i]   = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // One clock: model predicts, DUT output is compared after the edge.
  task automatic tick();
    int         s;
    bit         eff;
    logic [7:0] want;
    logic [7:0] got;
    kif.zero = (m_cnt == 31) || force_zero;
    s = m_cnt;
    if (rst) begin
      model_clear();
      want = 8'h00;
    end else begin
      eff  = m_req[s] | m_pend[s];
      want = {eff & !m_on[s], !eff & m_on[s], 5'(s), eff};
      m_on[s]   = eff;
      m_pend[s] = 1'b0;
      if (kif.kon_wr) begin
        for (int g = 0; g < 4; g++) begin
          m_req[g*8 + int'(kif.kon_ch)] = kif.kon_op[op_of_grp[g]];
        end
      end
      if (kif.csm_trig) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b1;
      end
      m_cnt = kif.zero ? 0 : (m_cnt + 1) % 32;
    end
    @(posedge clk);
    #1;
    got = {kif.keyon, kif.keyoff, kif.kon_slot, kif.kon_state};
    check($sformatf("cycle slot%0d {on,off,slot,state}", s), 32'(got), 32'(want));
    if (kif.keyon)  on_cnt[kif.kon_slot]++;
    if (kif.keyoff) off_cnt[kif.kon_slot]++;
    kif.kon_wr   = 1'b0;
    kif.csm_trig = 1'b0;
    force_zero   = 1'b0;
  endtask

  function automatic vec_t mk(int at, bit wr, bit trig, int ch, int op, int run,
                              logic [31:0] on_m, logic [31:0] off_m);
    vec_t v;
    v.at = at; v.wr = wr; v.trig = trig; v.ch = 3'(ch); v.op = 4'(op);
    v.run = run; v.on_mask = on_m; v.off_mask = off_m;
    return v;
  endfunction

  // Wait for the slot counter, apply the write/trigger, then count pulses
  // per slot over the window and compare with the expected slot masks.
  task automatic run_vec(input string name, input vec_t v);
    logic [31:0] gon, goff;
    int tot;
    for (int k = 0; k < 40 && m_cnt != v.at; k++) tick();
    for (int i = 0; i < 32; i++) begin
      on_cnt[i]  = 0;
      off_cnt[i] = 0;
    end
    kif.kon_wr   = v.wr;
    kif.kon_ch   = v.ch;
    kif.kon_op   = v.op;
    kif.csm_trig = v.trig;
    for (int k = 0; k < v.run; k++) tick();
    tot = 0;
    for (int i = 0; i < 32; i++) begin
      gon[i]  = (on_cnt[i] == 1);
      goff[i] = (off_cnt[i] == 1);
      tot += on_cnt[i] + off_cnt[i];
    end
    check({name, " keyon slots"}, gon, v.on_mask);
    check({name, " keyoff slots"}, goff, v.off_mask);
    check({name, " pulse total"}, 32'(tot), 32'($countones(v.on_mask) + $countones(v.off_mask)));
    $display("%s: at cnt %0d wr=%0b ch=%0d op=%b trig=%0b run=%0d -> on %h off %h",
             name, v.at, v.wr, v.ch, v.op, v.trig, v.run, gon, goff);
  endtask

  initial begin
    rst          = 1'b1;
    kif.zero     = 1'b0;
    kif.kon_wr   = 1'b0;
    kif.kon_ch   = 3'd0;
    kif.kon_op   = 4'd0;
    kif.csm_trig = 1'b0;
    force_zero   = 1'b0;
    model_clear();

    tick();
    tick();
    rst = 1'b0;

    // Resynchronise the counter from an arbitrary point.
    for (int k = 0; k < 40 && m_cnt != 10; k++) tick();
    force_zero = 1'b1;
    tick();

    vecs.push_back(mk(20, 1, 0, 3, 4'b0001, 96, 32'h0000_0008, 32'h0));
    vecs.push_back(mk(20, 1, 0, 3, 4'b0000, 64, 32'h0, 32'h0000_0008));
    vecs.push_back(mk( 8, 1, 0, 5, 4'b1111, 64, 32'h2020_2020, 32'h0));
    vecs.push_back(mk( 8, 1, 0, 5, 4'b0000, 64, 32'h0, 32'h2020_2020));
    vecs.push_back(mk( 8, 1, 0, 5, 4'b0100, 64, 32'h0000_2000, 32'h0));
    vecs.push_back(mk( 8, 1, 0, 5, 4'b0010, 64, 32'h0020_0000, 32'h0000_2000));
    vecs.push_back(mk( 8, 1, 0, 5, 4'b0000, 64, 32'h0, 32'h0020_0000));
    vecs.push_back(mk( 0, 1, 0, 0, 4'b0001, 32, 32'h0, 32'h0));
    vecs.push_back(mk( 0, 0, 0, 0, 4'b0000,  1, 32'h0000_0001, 32'h0));
    vecs.push_back(mk( 5, 1, 0, 0, 4'b0000, 64, 32'h0, 32'h0000_0001));
    vecs.push_back(mk( 4, 0, 1, 0, 4'b0000, 33, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk( 5, 0, 0, 0, 4'b0000, 32, 32'h0, 32'hFFFF_FFFF));
    vecs.push_back(mk(10, 1, 0, 7, 4'b0001, 64, 32'h0000_0080, 32'h0));
    vecs.push_back(mk(10, 0, 1, 0, 4'b0000, 33, 32'hFFFF_FF7F, 32'h0));
    vecs.push_back(mk(11, 0, 0, 0, 4'b0000, 32, 32'h0, 32'hFFFF_FF7F));
    vecs.push_back(mk(12, 1, 1, 7, 4'b0000, 33, 32'hFFFF_FF7F, 32'h0));
    vecs.push_back(mk(13, 0, 0, 0, 4'b0000, 32, 32'h0, 32'hFFFF_FFFF));
    vecs.push_back(mk(20, 0, 1, 0, 4'b0000, 33, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(21, 1, 0, 2, 4'b0001, 32, 32'h0, 32'hFFFF_FFFB));
    vecs.push_back(mk( 0, 1, 0, 2, 4'b0000, 64, 32'h0, 32'h0000_0004));
    vecs.push_back(mk( 3, 1, 0, 1, 4'b0001, 64, 32'h0000_0002, 32'h0));
    vecs.push_back(mk( 3, 1, 0, 1, 4'b0001, 64, 32'h0, 32'h0));
    vecs.push_back(mk(10, 1, 0, 4, 4'b0001,  1, 32'h0, 32'h0));
    vecs.push_back(mk(11, 1, 0, 4, 4'b0000, 63, 32'h0, 32'h0));
    vecs.push_back(mk( 3, 1, 0, 1, 4'b0000, 64, 32'h0, 32'h0000_0002));

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of operation: slot 2 on, no keyoff afterwards,
    // and a fresh write is needed to key it on again.
    run_vec("rst_pre", mk(0, 1, 0, 2, 4'b0001, 64, 32'h0000_0004, 32'h0));
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst outputs", 32'({kif.keyon, kif.keyoff, kif.kon_slot, kif.kon_state}), 32'h0);
    run_vec("rst_quiet", mk(5, 0, 0, 0, 4'b0000, 96, 32'h0, 32'h0));
    run_vec("rst_rewrite", mk(5, 1, 0, 2, 4'b0001, 64, 32'h0000_0004, 32'h0));
    run_vec("rst_clean", mk(5, 1, 0, 2, 4'b0000, 64, 32'h0, 32'h0000_0004));

    // Randomized traffic, every cycle compared against the model.
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 999) == 0);
      kif.kon_wr   = ($urandom_range(0, 5) == 0);
      kif.kon_ch   = 3'($urandom_range(0, 7));
      kif.kon_op   = 4'($urandom);
      kif.csm_trig = ($urandom_range(0, 149) == 0);
      force_zero   = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
